sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Single-clock, parametrised FIFO: next generation of the team's FIFO for same-domain buffering.
//   Adds fill level, programmable almost-full/almost-empty watermarks and a selectable
//   first-word-fall-through (FWFT) read mode. Optional sticky overflow/underflow error flags.
//   Sits between a producer and a consumer that share one clock, e.g. behind tt_um pin logic.
// PARAMETERS
//   DATA_WIDTH         4   bits per word
//   ADDRESS_WIDTH      5   depth = 2**ADDRESS_WIDTH words (default 32)
//   ALMOST_FULL_LEVEL  28  almost_full asserted when fill_level >= this value
//   ALMOST_EMPTY_LEVEL 4   almost_empty asserted when fill_level <= this value
//   FWFT               0   0 = registered read (1-cycle latency), 1 = first-word-fall-through
// PORTS
//   clock            in   1                 single clock, all logic on rising edge
//   reset            in   1                 synchronous, active-high
//   write_data       in   DATA_WIDTH        word to store
//   write_increment  in   1                 write request
//   read_increment   in   1                 read request (FWFT: pop/acknowledge of head word)
//   read_data        out  DATA_WIDTH        read word
//   empty            out  1                 no words stored
//   full             out  1                 2**ADDRESS_WIDTH words stored
//   almost_empty     out  1                 fill_level <= ALMOST_EMPTY_LEVEL
//   almost_full      out  1                 fill_level >= ALMOST_FULL_LEVEL
//   fill_level       out  ADDRESS_WIDTH+1   words currently stored, 0..2**ADDRESS_WIDTH
//   overflow         out  1                 sticky: write attempted while full
//   underflow        out  1                 sticky: read attempted while empty
// BEHAVIOUR
//   - Reset (sampled on clock edge): pointers=0, fill_level=0, empty=1, full=0, almost_empty=1,
//     almost_full=0, read_data=0, overflow=0, underflow=0. Memory contents not reset.
//     Reset wins over any same-cycle request; reset mid-operation discards all stored words.
//   - Write accepted iff write_increment && !full; data stored at write pointer, pointer +1.
//   - Read accepted iff read_increment && !empty; read pointer +1.
//   - Pointers are ADDRESS_WIDTH+1 bits; wrap modulo 2**(ADDRESS_WIDTH+1); the MSB
//     distinguishes full from empty. fill_level = write_ptr - read_ptr (modulo, same width).
//   - All status outputs registered; updated the cycle after the accepted op that changes them.
//   - Simultaneous accepted write+read: fill_level unchanged; flags unchanged.
//   - When full: write rejected even if same-cycle read accepted (level becomes 2**AW-1).
//   - When empty: read rejected even if same-cycle write accepted (level becomes 1).
//   - FWFT=0: read_data registered; accepted read at edge N -> word visible after edge N;
//     read_data holds its last value when no read is accepted.
//   - FWFT=1: read_data = word at read pointer whenever empty=0; write into empty FIFO at
//     edge N -> empty=0 and word on read_data after edge N; read_increment pops it.
//     read_data undefined-but-stable value when empty=1 (bench must not check it).
//   - Rejected requests change no pointer, level or data.
// CONFIGURATION
//   - Macro SYNC_FIFO_ERROR_FLAGS_EN defined: overflow set on edge where write_increment && full;
//     underflow set on edge where read_increment && empty; both remain set until reset.
//   - Macro not defined: overflow and underflow tied to 0; no flag registers.
// TESTING (defaults unless stated)
//   1. Reset, write 32 words 0x0..0xF,0x0..0xF -> full=1 after 32nd edge, fill_level=32,
//      almost_full=1 from level 28; 33rd write ignored, fill_level stays 32.
//   2. From (1), read 32 words, FWFT=0 -> read_data sequence matches write order one cycle
//      after each read; empty=1 after 32nd read; almost_empty=1 from level 4.
//   3. FWFT=1: write 0xA to empty FIFO -> next cycle empty=0, read_data=0xA without read;
//      read_increment -> empty=1 next cycle.
//   4. Level 16, write+read same cycle for 100 cycles -> fill_level stays 16, data ordered,
//      pointers wrap cleanly. Full + both -> only read accepted, level 31.
//   5. With SYNC_FIFO_ERROR_FLAGS_EN: write at full -> overflow=1, read at empty ->
//      underflow=1, both held; reset -> both 0. Without macro: both always 0.
//   6. Reset asserted at level 10 mid-write -> next cycle empty=1, fill_level=0, read_data=0.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param_if
// Description : Handshake and status bundle between a producer/consumer and
//               the single-clock FIFO sync_fifo_param.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH    = 4,
    parameter int ADDRESS_WIDTH = 5
);
    logic [DATA_WIDTH-1:0]  write_data;
    logic                   write_increment;
    logic                   read_increment;
    logic [DATA_WIDTH-1:0]  read_data;
    logic                   empty;
    logic                   full;
    logic                   almost_empty;
    logic                   almost_full;
    logic [ADDRESS_WIDTH:0] fill_level;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output write_data, write_increment, read_increment,
        input  read_data, empty, full, almost_empty, almost_full,
               fill_level, overflow, underflow
    );

    modport slave (
        input  write_data, write_increment, read_increment,
        output read_data, empty, full, almost_empty, almost_full,
               fill_level, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Single-clock FIFO with fill level, almost-full/almost-empty
//               watermarks and registered or first-word-fall-through reads.
//               Define SYNC_FIFO_ERROR_FLAGS_EN for sticky overflow/underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_WIDTH         = 4,
    parameter int ADDRESS_WIDTH      = 5,
    parameter int ALMOST_FULL_LEVEL  = 28,
    parameter int ALMOST_EMPTY_LEVEL = 4,
    parameter int FWFT               = 0
) (
    input  wire logic          clock,
    input  wire logic          reset,
    sync_fifo_param_if.slave   bus
);
    localparam int                 c_depth_int = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] c_depth    = (ADDRESS_WIDTH+1)'(c_depth_int);
    localparam logic [ADDRESS_WIDTH:0] c_af_level = (ADDRESS_WIDTH+1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDRESS_WIDTH:0] c_ae_level = (ADDRESS_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

    logic [DATA_WIDTH-1:0]  r_mem [c_depth_int];
    logic [ADDRESS_WIDTH:0] r_wr_ptr;
    logic [ADDRESS_WIDTH:0] r_rd_ptr;
    logic [ADDRESS_WIDTH:0] r_fill_level;
    logic                   r_empty;
    logic                   r_full;
    logic                   r_almost_empty;
    logic                   r_almost_full;

    logic                   w_wr_en;
    logic                   w_rd_en;
    logic [ADDRESS_WIDTH:0] w_wr_ptr_nxt;
    logic [ADDRESS_WIDTH:0] w_rd_ptr_nxt;
    logic [ADDRESS_WIDTH:0] w_level_nxt;

    // Requests are qualified by the registered flags, so a full FIFO rejects a
    // write even when a read is accepted in the same cycle (and vice versa).
    assign w_wr_en      = bus.write_increment && !r_full;
    assign w_rd_en      = bus.read_increment  && !r_empty;
    assign w_wr_ptr_nxt = r_wr_ptr + {{ADDRESS_WIDTH{1'b0}}, w_wr_en};
    assign w_rd_ptr_nxt = r_rd_ptr + {{ADDRESS_WIDTH{1'b0}}, w_rd_en};
    assign w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

    always_ff @(posedge clock) begin
        if (w_wr_en && !reset) begin
            r_mem[r_wr_ptr[ADDRESS_WIDTH-1:0]] <= bus.write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_fill_level   <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_fill_level   <= w_level_nxt;
            r_empty        <= (w_level_nxt == '0);
            r_full         <= (w_level_nxt == c_depth);
            r_almost_empty <= (w_level_nxt <= c_ae_level);
            r_almost_full  <= (w_level_nxt >= c_af_level);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; forced to zero while empty so
            // the output is stable and matches the post-reset value.
            assign bus.read_data = r_empty ? '0 : r_mem[r_rd_ptr[ADDRESS_WIDTH-1:0]];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] r_read_data;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_read_data <= '0;
                end else if (w_rd_en) begin
                    r_read_data <= r_mem[r_rd_ptr[ADDRESS_WIDTH-1:0]];
                end
            end

            assign bus.read_data = r_read_data;
        end
    endgenerate

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.write_increment && r_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.read_increment && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.fill_level   = r_fill_level;
    assign bus.empty        = r_empty;
    assign bus.full         = r_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.almost_full  = r_almost_full;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param, registered and FWFT
//               instances driven in lockstep against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;
    localparam int DW    = 4;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] wdata = '0;
    logic          winc = 1'b0;
    logic          rinc = 1'b0;
    bit            checking = 1'b0;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) if0 ();
    sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) if1 ();

    assign if0.write_data      = wdata;
    assign if0.write_increment = winc;
    assign if0.read_increment  = rinc;
    assign if1.write_data      = wdata;
    assign if1.write_increment = winc;
    assign if1.read_increment  = rinc;

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALMOST_FULL_LEVEL(28),
                      .ALMOST_EMPTY_LEVEL(4), .FWFT(0)) u_dut_reg (
        .clock (clk),
        .reset (rst),
        .bus   (if0.slave)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALMOST_FULL_LEVEL(28),
                      .ALMOST_EMPTY_LEVEL(4), .FWFT(1)) u_dut_fwft (
        .clock (clk),
        .reset (rst),
        .bus   (if1.slave)
    );

    // Reference: contents as a queue, registered read word, sticky flags.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd0 = '0;
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
    bit            m_wr_ok;
    bit            m_rd_ok;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_rd0 = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_wr_ok = winc && (mq.size() < DEPTH);
            m_rd_ok = rinc && (mq.size() > 0);
            if (FLAGS_EN && winc && mq.size() == DEPTH) m_ovf = 1'b1;
            if (FLAGS_EN && rinc && mq.size() == 0)     m_udf = 1'b1;
            if (m_rd_ok) m_rd0 = mq.pop_front();
            if (m_wr_ok) mq.push_back(wdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("fill_level",   32'(if0.fill_level),   32'(mq.size()));
            chk("empty",        32'(if0.empty),        32'(mq.size() == 0));
            chk("full",         32'(if0.full),         32'(mq.size() == DEPTH));
            chk("almost_empty", 32'(if0.almost_empty), 32'(mq.size() <= 4));
            chk("almost_full",  32'(if0.almost_full),  32'(mq.size() >= 28));
            chk("read_data_reg",32'(if0.read_data),    32'(m_rd0));
            chk("overflow",     32'(if0.overflow),     32'(m_ovf));
            chk("underflow",    32'(if0.underflow),    32'(m_udf));
            chk("fwft_level",   32'(if1.fill_level),   32'(mq.size()));
            chk("fwft_empty",   32'(if1.empty),        32'(mq.size() == 0));
            if (mq.size() != 0) begin
                chk("fwft_read_data", 32'(if1.read_data), 32'(mq[0]));
            end
        end
    end

    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
        winc  = w;
        wdata = d;
        rinc  = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0);
        rst = 1'b0;
        checking = 1'b1;
        chk("reset_empty",   32'(if0.empty),        32'd1);
        chk("reset_level",   32'(if0.fill_level),   32'd0);
        chk("reset_ae",      32'(if0.almost_empty), 32'd1);
        chk("reset_rd",      32'(if0.read_data),    32'd0);

        // Fill to capacity; watermark crosses between level 27 and 28.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, DW'(i), 1'b0);
            if (i == 26) chk("af_at_27", 32'(if0.almost_full), 32'd0);
            if (i == 27) chk("af_at_28", 32'(if0.almost_full), 32'd1);
        end
        chk("full_after_32", 32'(if0.full),       32'd1);
        chk("level_32",      32'(if0.fill_level), 32'd32);
        cycle(1'b1, 4'h5, 1'b0);
        chk("level_after_33rd", 32'(if0.fill_level), 32'd32);
        chk("overflow_lit",     32'(if0.overflow),   32'(FLAGS_EN));

        // Drain in write order, one word per read.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1);
            chk("drain_data", 32'(if0.read_data), 32'(i % 16));
            if (i == 26) chk("ae_at_5", 32'(if0.almost_empty), 32'd0);
            if (i == 27) chk("ae_at_4", 32'(if0.almost_empty), 32'd1);
        end
        chk("empty_after_drain", 32'(if0.empty), 32'd1);
        cycle(1'b0, '0, 1'b1);
        chk("underflow_lit", 32'(if0.underflow), 32'(FLAGS_EN));

        // FWFT head word appears without a read.
        cycle(1'b1, 4'hA, 1'b0);
        chk("fwft_nonempty", 32'(if1.empty),     32'd0);
        chk("fwft_head",     32'(if1.read_data), 32'hA);
        chk("reg_rd_hold",   32'(if0.read_data), 32'hF);
        cycle(1'b0, '0, 1'b0);
        chk("fwft_head_stable", 32'(if1.read_data), 32'hA);
        cycle(1'b0, '0, 1'b1);
        chk("fwft_popped", 32'(if1.empty),     32'd1);
        chk("reg_rd_A",    32'(if0.read_data), 32'hA);

        // Empty with both requests: only the write lands.
        cycle(1'b1, 4'h7, 1'b1);
        chk("empty_both_level", 32'(if0.fill_level), 32'd1);
        chk("empty_both_rd",    32'(if0.read_data),  32'hA);
        cycle(1'b0, '0, 1'b1);

        // Steady state at level 16 with pointer wrap.
        for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, DW'(i + 3), 1'b1);
        chk("steady_level", 32'(if0.fill_level), 32'd16);
        for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i * 5), 1'b0);
        chk("refull", 32'(if0.full), 32'd1);
        cycle(1'b1, 4'h9, 1'b1);
        chk("full_both_level", 32'(if0.fill_level), 32'd31);
        chk("full_both_full",  32'(if0.full),       32'd0);

        // Reset clears the sticky flags.
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0);
        rst = 1'b0;
        chk("rst_overflow",  32'(if0.overflow),  32'd0);
        chk("rst_underflow", 32'(if0.underflow), 32'd0);

        // Reset at level 10 during a write discards everything.
        for (int i = 0; i < 10; i++) cycle(1'b1, DW'(i + 1), 1'b0);
        cycle(1'b1, 4'hC, 1'b1);
        chk("pre_rst_rd",    32'(if0.read_data),  32'd1);
        chk("pre_rst_level", 32'(if0.fill_level), 32'd10);
        rst = 1'b1;
        cycle(1'b1, 4'h3, 1'b0);
        rst = 1'b0;
        chk("mid_rst_empty", 32'(if0.empty),      32'd1);
        chk("mid_rst_level", 32'(if0.fill_level), 32'd0);
        chk("mid_rst_rd",    32'(if0.read_data),  32'd0);
        cycle(1'b0, '0, 1'b0);

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
